// File: rtl/pmem_responder_pkg.sv
// Shared types and constants for the pmem_responder memory model.
package pmem_responder_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} port_state_t;

  localparam int CNT_W = 16;

  localparam logic [31:0] FAULT_RDATA = 32'h0;

endpackage

// File: rtl/pmem_port_fsm.sv
// Per-port request FSM: accepts a held request, counts out LATENCY cycles,
// pulses resp, and aborts if the request is dropped while waiting.
module pmem_port_fsm
  import pmem_responder_pkg::*;
#(
  parameter int LATENCY   = 2,
  parameter int PAYLOAD_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req,
  input  logic [PAYLOAD_W-1:0] payload,
  output logic                 accept,
  output logic                 resp,
  output logic                 abort,
  output logic                 resp_load,
  output logic [PAYLOAD_W-1:0] payload_cur
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  port_state_t          state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [PAYLOAD_W-1:0] payload_q;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          accept    = 1'b1;
          cnt_nxt   = CNT_INIT;
          state_nxt = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (!req) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else begin
          // RESP is entered as the counter reaches zero, so IDLE + (LATENCY-1)
          // WAIT cycles put resp exactly LATENCY cycles after the request.
          cnt_nxt = cnt - CNT_W'(1);
          if (cnt <= CNT_W'(1)) state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign resp        = (state == RESP);
  assign resp_load   = (state_nxt == RESP);
  // In IDLE the request is being accepted this cycle, so the live inputs apply.
  assign payload_cur = (state == IDLE) ? payload : payload_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) payload_q <= payload;
  end

endmodule

// File: rtl/pmem_responder.sv
// Two-port memory responder: read-only port A, read/write port B with byte
// mask, one shared word array, sticky fault flag.
module pmem_responder
  import pmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY_A   = 2,
  parameter int LATENCY_B   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read_a,
  input  logic [31:0] address_a,
  output logic        resp_a,
  output logic [31:0] rdata_a,
  input  logic        read_b,
  input  logic        write,
  input  logic [3:0]  wmask,
  input  logic [31:0] address_b,
  input  logic [31:0] wdata,
  output logic        resp_b,
  output logic [31:0] rdata_b,
  output logic        pmem_error
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int B_W   = 1 + 4 + 32 + 32;

  logic [31:0] mem [DEPTH_WORDS];

  function automatic logic addr_fault(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> (2 + IDX_W)) != 32'h0);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
    return a[2 +: IDX_W];
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  mask);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) if (mask[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  logic           acc_a, abort_a, load_a;
  logic [31:0]    a_addr;
  logic           acc_b, abort_b, load_b;
  logic [B_W-1:0] b_cur;
  logic           b_is_wr, b_commit;
  logic [3:0]     b_wmask;
  logic [31:0]    b_wdata, b_addr, rd_a_word;

  pmem_port_fsm #(.LATENCY(LATENCY_A), .PAYLOAD_W(32)) u_port_a (
    .clk(clk), .rst(rst), .req(read_a), .payload(address_a),
    .accept(acc_a), .resp(resp_a), .abort(abort_a), .resp_load(load_a),
    .payload_cur(a_addr)
  );

  // A simultaneous read+write is latched as a plain read.
  pmem_port_fsm #(.LATENCY(LATENCY_B), .PAYLOAD_W(B_W)) u_port_b (
    .clk(clk), .rst(rst), .req(read_b | write),
    .payload({write & ~read_b, wmask, wdata, address_b}),
    .accept(acc_b), .resp(resp_b), .abort(abort_b), .resp_load(load_b),
    .payload_cur(b_cur)
  );

  assign {b_is_wr, b_wmask, b_wdata, b_addr} = b_cur;
  assign b_commit = resp_b && b_is_wr && !addr_fault(b_addr);

  // rdata is loaded on the edge entering RESP; a B write committing on that
  // same edge is forwarded so A sees the array as it stands in its RESP cycle.
  always_comb begin
    rd_a_word = mem[word_idx(a_addr)];
    if (b_commit && (word_idx(b_addr) == word_idx(a_addr)))
      rd_a_word = merge_bytes(rd_a_word, b_wdata, b_wmask);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_a <= '0;
      rdata_b <= '0;
    end else begin
      if (load_a) rdata_a <= addr_fault(a_addr) ? FAULT_RDATA : rd_a_word;
      else        rdata_a <= '0;
      if (load_b && !b_is_wr)
        rdata_b <= addr_fault(b_addr) ? FAULT_RDATA : mem[word_idx(b_addr)];
      else
        rdata_b <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && b_commit) begin
      for (int i = 0; i < 4; i++)
        if (b_wmask[i]) mem[word_idx(b_addr)][8*i +: 8] <= b_wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      pmem_error <= 1'b0;
    else if ((acc_a && addr_fault(address_a)) ||
             (acc_b && (addr_fault(address_b) || (read_b && write))) ||
             abort_a || abort_b)
      pmem_error <= 1'b1;
  end

endmodule

// File: tb/tb_pmem_responder.sv
// Self-checking bench for pmem_responder: vector table plus hand sequences,
// with per-port scoreboards checked on every resp pulse.
module tb_pmem_responder;

  localparam int LAT_A = 2;
  localparam int LAT_B = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        read_a;
  logic [31:0] address_a;
  logic        resp_a;
  logic [31:0] rdata_a;
  logic        read_b, write;
  logic [3:0]  wmask;
  logic [31:0] address_b, wdata;
  logic        resp_b;
  logic [31:0] rdata_b;
  logic        pmem_error;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    bit          chk;
    logic [31:0] val;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  typedef struct {
    bit          pa;
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  wm;
    bit          chk;
    logic [31:0] exp;
    int          lat;
    bit          err;
  } vec_t;

  vec_t vecs[15];

  pmem_responder #(.DEPTH_WORDS(1024), .LATENCY_A(LAT_A), .LATENCY_B(LAT_B)) dut (
    .clk(clk), .rst(rst),
    .read_a(read_a), .address_a(address_a), .resp_a(resp_a), .rdata_a(rdata_a),
    .read_b(read_b), .write(write), .wmask(wmask), .address_b(address_b),
    .wdata(wdata), .resp_b(resp_b), .rdata_b(rdata_b), .pmem_error(pmem_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every resp pops the oldest expectation for its port.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (resp_a) begin
        if (qa.size() == 0) check("unexpected_resp_a", 32'h1, 32'h0);
        else begin
          e = qa.pop_front();
          if (e.chk) check("rdata_a", rdata_a, e.val);
        end
      end else if (rdata_a != 32'h0) check("rdata_a_idle", rdata_a, 32'h0);
      if (resp_b) begin
        if (qb.size() == 0) check("unexpected_resp_b", 32'h1, 32'h0);
        else begin
          e = qb.pop_front();
          if (e.chk) check("rdata_b", rdata_b, e.val);
        end
      end else if (rdata_b != 32'h0) check("rdata_b_idle", rdata_b, 32'h0);
    end
  end

  function automatic vec_t mk(bit pa, bit rd, bit wr, logic [31:0] addr, logic [31:0] wd,
                              logic [3:0] wm, bit chk, logic [31:0] exp, bit err);
    vec_t v;
    v.pa = pa; v.rd = rd; v.wr = wr; v.addr = addr; v.wd = wd; v.wm = wm;
    v.chk = chk; v.exp = exp; v.err = err;
    v.lat = pa ? LAT_A : LAT_B;
    return v;
  endfunction

  // Drive one transaction from the start of a cycle, hold it until resp,
  // and check the response latency and the single-cycle pulse width.
  task automatic txn(input bit pa, input bit rd, input bit wr, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [3:0] wm, input bit chk,
                     input logic [31:0] exp, input int lat);
    int   k;
    exp_t e;
    e.chk = chk;
    e.val = exp;
    k = 0;
    @(posedge clk); #1;
    if (pa) begin
      read_a = 1'b1; address_a = addr; qa.push_back(e);
    end else begin
      read_b = rd; write = wr; address_b = addr; wdata = wd; wmask = wm; qb.push_back(e);
    end
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (pa ? resp_a : resp_b) begin
        k = i;
        break;
      end
    end
    check(pa ? "latency_a" : "latency_b", 32'(k), 32'(lat));
    if (pa) read_a = 1'b0;
    else begin read_b = 1'b0; write = 1'b0; end
    @(posedge clk); #1;
    check(pa ? "pulse_a" : "pulse_b", {31'h0, pa ? resp_a : resp_b}, 32'h0);
  endtask

  initial begin
    bit seen;
    rst = 1'b1;
    read_a = 1'b0; address_a = '0;
    read_b = 1'b0; write = 1'b0; wmask = '0; address_b = '0; wdata = '0;

    vecs[0]  = mk(0, 0, 1, 32'h10,   32'hDEADBEEF, 4'hF, 0, 32'h0,        0);
    vecs[1]  = mk(1, 1, 0, 32'h10,   32'h0,        4'h0, 1, 32'hDEADBEEF, 0);
    vecs[2]  = mk(0, 0, 1, 32'h20,   32'h11223344, 4'hF, 0, 32'h0,        0);
    vecs[3]  = mk(0, 0, 1, 32'h20,   32'hAABBCCDD, 4'h5, 0, 32'h0,        0);
    vecs[4]  = mk(0, 1, 0, 32'h20,   32'h0,        4'h0, 1, 32'h11BB33DD, 0);
    vecs[5]  = mk(0, 0, 1, 32'h20,   32'hFFFFFFFF, 4'h0, 0, 32'h0,        0);
    vecs[6]  = mk(1, 1, 0, 32'h20,   32'h0,        4'h0, 1, 32'h11BB33DD, 0);
    vecs[7]  = mk(0, 0, 1, 32'h14,   32'h0,        4'hF, 0, 32'h0,        0);
    vecs[8]  = mk(0, 0, 1, 32'h00,   32'h0BADF00D, 4'hF, 0, 32'h0,        0);
    vecs[9]  = mk(1, 1, 0, 32'h00,   32'h0,        4'h0, 1, 32'h0BADF00D, 0);
    vecs[10] = mk(0, 1, 0, 32'h3,    32'h0,        4'h0, 1, 32'h0,        1);
    vecs[11] = mk(1, 1, 0, 32'h10,   32'h0,        4'h0, 1, 32'hDEADBEEF, 1);
    vecs[12] = mk(0, 0, 1, 32'h1000, 32'h12345678, 4'hF, 0, 32'h0,        1);
    vecs[13] = mk(0, 1, 0, 32'h00,   32'h0,        4'h0, 1, 32'h0BADF00D, 1);
    vecs[14] = mk(1, 1, 0, 32'h1002, 32'h0,        4'h0, 1, 32'h0,        1);

    repeat (2) @(posedge clk);
    #1;
    check("rst_resp_a", {31'h0, resp_a}, 32'h0);
    check("rst_resp_b", {31'h0, resp_b}, 32'h0);
    check("rst_rdata_a", rdata_a, 32'h0);
    check("rst_rdata_b", rdata_b, 32'h0);
    check("rst_pmem_error", {31'h0, pmem_error}, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      txn(vecs[i].pa, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].wm,
          vecs[i].chk, vecs[i].exp, vecs[i].lat);
      check($sformatf("vec%0d_pmem_error", i), {31'h0, pmem_error}, {31'h0, vecs[i].err});
    end

    // B write issued one cycle before A read so both reach RESP together.
    fork
      txn(0, 0, 1, 32'h14, 32'hFFFFFFFF, 4'hF, 0, 32'h0, LAT_B);
      begin
        @(posedge clk);
        txn(1, 1, 0, 32'h14, 32'h0, 4'h0, 1, 32'h0, LAT_A);
      end
    join
    txn(1, 1, 0, 32'h14, 32'h0, 4'h0, 1, 32'hFFFFFFFF, LAT_A);

    // Request dropped during WAIT.
    @(posedge clk); #1;
    read_b = 1'b1; address_b = 32'h30;
    @(posedge clk); #1;
    read_b = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (resp_b) seen = 1'b1;
    end
    check("drop_no_resp", {31'h0, seen}, 32'h0);
    check("drop_pmem_error", {31'h0, pmem_error}, 32'h1);
    txn(0, 1, 0, 32'h10, 32'h0, 4'h0, 1, 32'hDEADBEEF, LAT_B);

    // Reset in the middle of a pending write.
    txn(0, 0, 1, 32'h40, 32'h5555AAAA, 4'hF, 0, 32'h0, LAT_B);
    @(posedge clk); #1;
    write = 1'b1; address_b = 32'h40; wdata = 32'hFFFFFFFF; wmask = 4'hF;
    @(posedge clk); #1;
    rst = 1'b1; write = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstmid_pmem_error", {31'h0, pmem_error}, 32'h0);
    check("rstmid_rdata_b", rdata_b, 32'h0);
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (resp_b) seen = 1'b1;
    end
    check("rstmid_no_resp", {31'h0, seen}, 32'h0);
    txn(1, 1, 0, 32'h40, 32'h0, 4'h0, 1, 32'h5555AAAA, LAT_A);
    check("rstmid_err_clear", {31'h0, pmem_error}, 32'h0);

    // read_b and write together: flagged, executed as a read, nothing written.
    txn(0, 1, 1, 32'h40, 32'h0, 4'hF, 1, 32'h5555AAAA, LAT_B);
    check("rdwr_pmem_error", {31'h0, pmem_error}, 32'h1);
    txn(1, 1, 0, 32'h40, 32'h0, 4'h0, 1, 32'h5555AAAA, LAT_A);

    repeat (2) @(posedge clk);
    check("qa_drained", 32'(qa.size()), 32'h0);
    check("qb_drained", 32'(qb.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
